// File: rtl/key_replay_ctrl.sv
// key_replay_ctrl: record/replay sequencer for the keyboard front end.
// Samples {button,key} on a slow tick, stores run-length entries
// {button,key,dur} and plays them back on request. o_light shows the live
// input when not playing and the recorded note data while playing.
module key_replay_ctrl #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [6:0]             i_key,
  input  logic [2:0]             i_button,
  input  logic                   i_rec,
  input  logic                   i_replay,
  output logic [10:0]            o_light,
  output logic                   o_recording,
  output logic                   o_playing,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [1:0]             o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int EW = 10 + DUR_W;

  localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE   = PW'(1);
  localparam logic [AW:0]      LAST_IDX  = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]      CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_presc;
  logic             r_rec_d;
  logic             r_replay_d;
  logic [AW:0]      r_count;     // also the write pointer: entries are appended in order
  logic             r_full;
  logic [9:0]       r_cur;
  logic [DUR_W-1:0] r_dur;
  logic [AW-1:0]    r_rd_ptr;
  logic [DUR_W-1:0] r_rem;
  logic [10:0]      r_light;
  logic [EW-1:0]    r_mem [DEPTH];

  logic [9:0]       w_live;
  logic             w_tick;
  logic             w_rec_rise;
  logic             w_rec_fall;
  logic             w_replay_rise;
  logic             w_extend;
  logic             w_wr_en;
  logic [EW-1:0]    w_wr_data;
  logic [DUR_W-1:0] w_first_dur;
  logic [DUR_W-1:0] w_next_dur;
  logic [9:0]       w_rd_note;
  logic             w_last_entry;

  assign w_live        = {i_button, i_key};
  assign w_tick        = (r_presc == TICK_LAST);
  assign w_rec_rise    = i_rec & ~r_rec_d;
  assign w_rec_fall    = ~i_rec & r_rec_d;
  assign w_replay_rise = i_replay & ~r_replay_d;

  // A tick keeps extending the current run only while the input is unchanged
  // and the duration has headroom; otherwise the run is closed and written.
  assign w_extend  = (w_live == r_cur) && (r_dur != DUR_MAX);
  assign w_wr_en   = (r_state == S_RECORD) && (w_rec_fall || (w_tick && !w_extend));
  assign w_wr_data = {r_cur, r_dur};

  assign w_first_dur  = r_mem[0][DUR_W-1:0];
  assign w_next_dur   = r_mem[r_rd_ptr + PTR_ONE][DUR_W-1:0];
  assign w_rd_note    = r_mem[r_rd_ptr][EW-1:DUR_W];
  assign w_last_entry = ({1'b0, r_rd_ptr} == (r_count - CNT_ONE));

  assign o_light     = r_light;
  assign o_recording = (r_state == S_RECORD);
  assign o_playing   = (r_state == S_PLAY);
  assign o_full      = r_full;
  assign o_count     = r_count;
  assign o_state     = r_state;

  // Free-running sample-tick prescaler and edge-detect registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_rec_d    <= 1'b0;
      r_replay_d <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : (r_presc + PRE_ONE);
      r_rec_d    <= i_rec;
      r_replay_d <= i_replay;
    end
  end

  // Record buffer; contents survive reset, r_count decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_count[AW-1:0]] <= w_wr_data;
    end
  end

  // Sequencer FSM: IDLE / RECORD / PLAY with run-length bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_cur    <= '0;
      r_dur    <= '0;
      r_rd_ptr <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // rec has priority over replay when both rise together
          if (w_rec_rise) begin
            r_state <= S_RECORD;
            r_count <= '0;
            r_full  <= 1'b0;
            r_cur   <= w_live;
            r_dur   <= DUR_ONE;
          end else if (w_replay_rise && (r_count != '0)) begin
            r_state  <= S_PLAY;
            r_rd_ptr <= '0;
            r_rem    <= w_first_dur;
          end
        end
        S_RECORD: begin
          if (w_rec_fall) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (w_extend) begin
              r_dur <= r_dur + DUR_ONE;
            end else begin
              r_cur <= w_live;
              r_dur <= DUR_ONE;
            end
          end
          // the write that fills the buffer ends recording immediately
          if (w_wr_en) begin
            r_count <= r_count + CNT_ONE;
            if (r_count == LAST_IDX) begin
              r_full  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_PLAY: begin
          if (w_replay_rise) begin
            r_rd_ptr <= '0;
            r_rem    <= w_first_dur;
          end else if (w_tick) begin
            if (r_rem == DUR_ONE) begin
              if (w_last_entry) begin
                r_state <= S_IDLE;
              end else begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_rem    <= w_next_dur;
              end
            end else begin
              r_rem <= r_rem - DUR_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // LED/note output: recorded note while playing, live input otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_light <= '0;
    end else if (r_state == S_PLAY) begin
      r_light <= {1'b1, w_rd_note};
    end else begin
      r_light <= {1'b0, w_live};
    end
  end

endmodule

// File: tb/tb_key_replay_ctrl.sv
// tb_key_replay_ctrl: two instances (DUR_W=8 and DUR_W=2) share one stimulus.
// Recordings are described as segments (value, ticks held); the expected buffer
// is the run-length split of those segments, and playback is checked once per
// tick period against the cumulative durations of the expected entries.
module tb_key_replay_ctrl;

  localparam int TICK  = 4;
  localparam int DEPTH = 4;
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  key = '0;
  logic [2:0]  button = '0;
  logic        rec = 1'b0;
  logic        replay = 1'b0;

  logic [10:0] light_a, light_b;
  logic        rec_a, rec_b, play_a, play_b, full_a, full_b;
  logic [2:0]  count_a, count_b;
  logic [1:0]  state_a, state_b;

  key_replay_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK), .DUR_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_button(button),
    .i_rec(rec), .i_replay(replay), .o_light(light_a), .o_recording(rec_a),
    .o_playing(play_a), .o_full(full_a), .o_count(count_a), .o_state(state_a)
  );

  key_replay_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK), .DUR_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_button(button),
    .i_rec(rec), .i_replay(replay), .o_light(light_b), .o_recording(rec_b),
    .o_playing(play_b), .o_full(full_b), .o_count(count_b), .o_state(state_b)
  );

  // bench-side clock-edge counter; ticks land on edges taking it to a multiple of TICK
  int edge_n;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] seg_v[$];
  int         seg_n[$];
  logic [9:0] exp_va[$], exp_vb[$];
  int         exp_da[$], exp_db[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance to the falling edge at which edge_n % TICK == p (always moves forward)
  task automatic to_phase(input int p);
    do @(negedge clk); while ((edge_n % TICK) != p);
  endtask

  // split each held segment into runs of at most max ticks, keep the first DEPTH
  task automatic model_record();
    exp_va.delete(); exp_da.delete(); exp_vb.delete(); exp_db.delete();
    foreach (seg_n[i]) begin
      int n;
      n = seg_n[i];
      while (n > 0) begin
        int c;
        c = (n > MAX_A) ? MAX_A : n;
        exp_va.push_back(seg_v[i]); exp_da.push_back(c); n -= c;
      end
      n = seg_n[i];
      while (n > 0) begin
        int c;
        c = (n > MAX_B) ? MAX_B : n;
        exp_vb.push_back(seg_v[i]); exp_db.push_back(c); n -= c;
      end
    end
    while (exp_va.size() > DEPTH) begin void'(exp_va.pop_back()); void'(exp_da.pop_back()); end
    while (exp_vb.size() > DEPTH) begin void'(exp_vb.pop_back()); void'(exp_db.pop_back()); end
  endtask

  // {playing, light} expected at the j-th tick period of playback
  function automatic logic [11:0] exp_play(input bit use_b, input int j, input logic [9:0] live);
    int acc;
    acc = 0;
    if (!use_b) begin
      foreach (exp_da[k]) begin
        if (j > acc && j <= acc + exp_da[k]) return {2'b11, exp_va[k]};
        acc += exp_da[k];
      end
    end else begin
      foreach (exp_db[k]) begin
        if (j > acc && j <= acc + exp_db[k]) return {2'b11, exp_vb[k]};
        acc += exp_db[k];
      end
    end
    return {2'b00, live};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic async_rst(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({tag, " light_a"}, 32'(light_a), 32'(0));
    check({tag, " light_b"}, 32'(light_b), 32'(0));
    check({tag, " recording"}, 32'(rec_a), 32'(0));
    check({tag, " playing"}, 32'(play_a), 32'(0));
    check({tag, " full"}, 32'(full_a), 32'(0));
    check({tag, " count_a"}, 32'(count_a), 32'(0));
    check({tag, " count_b"}, 32'(count_b), 32'(0));
    rec = 1'b0;
    replay = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_record(input string tag);
    rec = 1'b0;
    replay = 1'b0;
    to_phase(0);
    {button, key} = seg_v[0];
    rec = 1'b1;
    @(negedge clk);
    check({tag, " recording_a on"}, 32'(rec_a), 32'(1));
    check({tag, " recording_b on"}, 32'(rec_b), 32'(1));
    check({tag, " state agree"}, 32'(state_a), 32'(state_b));
    for (int w = 1; w < seg_n[0]; w++) to_phase(0);
    for (int i = 1; i < seg_v.size(); i++) begin
      {button, key} = seg_v[i];
      for (int w = 0; w < seg_n[i]; w++) to_phase(0);
    end
    rec = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_record();
    check({tag, " count_a"}, 32'(count_a), 32'(exp_va.size()));
    check({tag, " count_b"}, 32'(count_b), 32'(exp_vb.size()));
    check({tag, " full_a"}, 32'(full_a), 32'(exp_va.size() == DEPTH));
    check({tag, " full_b"}, 32'(full_b), 32'(exp_vb.size() == DEPTH));
    check({tag, " recording_a off"}, 32'(rec_a), 32'(0));
    check({tag, " recording_b off"}, 32'(rec_b), 32'(0));
  endtask

  task automatic do_play(input string tag, input bit poke_rec, input bit do_restart);
    int sa, sb, smax, smin, r, j;
    bit restarted;
    logic [11:0] e;
    sa = 0; sb = 0;
    foreach (exp_da[k]) sa += exp_da[k];
    foreach (exp_db[k]) sb += exp_db[k];
    smax = (sa > sb) ? sa : sb;
    smin = (sa < sb) ? sa : sb;
    r = (do_restart && smin >= 2) ? int'($urandom_range(2, smin)) : 0;
    rec = 1'b0;
    replay = 1'b0;
    to_phase(0);
    replay = 1'b1;
    restarted = 1'b0;
    j = 1;
    while (j <= smax + 1) begin
      to_phase(TICK - 1);
      e = exp_play(1'b0, j, {button, key});
      check($sformatf("%s light_a j%0d", tag, j), 32'(light_a), 32'(e[10:0]));
      check($sformatf("%s playing_a j%0d", tag, j), 32'(play_a), 32'(e[11]));
      e = exp_play(1'b1, j, {button, key});
      check($sformatf("%s light_b j%0d", tag, j), 32'(light_b), 32'(e[10:0]));
      check($sformatf("%s playing_b j%0d", tag, j), 32'(play_b), 32'(e[11]));
      check($sformatf("%s recording j%0d", tag, j), 32'({rec_a, rec_b}), 32'(0));
      if (j == 1) replay = 1'b0;
      if (poke_rec && j == 1 && !restarted) rec = 1'b1;
      to_phase(0);
      rec = 1'b0;
      if (!restarted && j == r) begin
        replay = 1'b1;
        restarted = 1'b1;
        j = 1;
      end else begin
        j++;
      end
    end
    replay = 1'b0;
    check({tag, " count_a kept"}, 32'(count_a), 32'(exp_va.size()));
    check({tag, " count_b kept"}, 32'(count_b), 32'(exp_vb.size()));
  endtask

  task automatic empty_replay(input string tag);
    replay = 1'b0;
    to_phase(0);
    replay = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_phase(TICK - 1);
      check($sformatf("%s playing_a %0d", tag, k), 32'(play_a), 32'(0));
      check($sformatf("%s playing_b %0d", tag, k), 32'(play_b), 32'(0));
      check($sformatf("%s light_a %0d", tag, k), 32'(light_a), 32'({1'b0, button, key}));
    end
    replay = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] v, prev;
    #1 rst = 1'b1;
    #1;
    check("reset light", 32'(light_a), 32'(0));
    check("reset count", 32'(count_a), 32'(0));
    check("reset flags", 32'({rec_a, play_a, full_a, rec_b, play_b, full_b}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // live path, one-cycle latency
    for (int k = 0; k < 4; k++) begin
      v = 10'($urandom_range(0, 1023));
      {button, key} = v;
      @(negedge clk);
      check($sformatf("live_a %0d", k), 32'(light_a), 32'({1'b0, v}));
      check($sformatf("live_b %0d", k), 32'(light_b), 32'({1'b0, v}));
    end

    empty_replay("empty");

    // two notes, 3 and 2 ticks; rec poke during playback must be ignored
    seg_v = '{10'h001, 10'h004}; seg_n = '{3, 2};
    do_record("two_notes");
    do_play("two_notes", 1'b1, 1'b0);

    // key changes every tick: buffer fills after the 4th write
    seg_v = '{10'h011, 10'h022, 10'h044, 10'h088, 10'h101, 10'h202}; seg_n = '{1, 1, 1, 1, 1, 1};
    do_record("fill");
    do_play("fill", 1'b0, 1'b1);

    // long hold: saturates at 3 in the DUR_W=2 instance
    seg_v = '{10'h010}; seg_n = '{5};
    do_record("sat");
    do_play("sat", 1'b0, 1'b0);

    // randomized recordings
    for (int rnd = 0; rnd < 6; rnd++) begin
      int ns;
      seg_v.delete(); seg_n.delete();
      ns = $urandom_range(1, 5);
      prev = 10'($urandom_range(0, 1023));
      for (int s = 0; s < ns; s++) begin
        do v = 10'($urandom_range(0, 1023)); while (v == prev);
        seg_v.push_back(v);
        seg_n.push_back($urandom_range(1, 7));
        prev = v;
      end
      do_record($sformatf("rnd%0d", rnd));
      do_play($sformatf("rnd%0d", rnd), rnd[0], 1'b1);
    end

    // reset in the middle of playback wipes the recording
    seg_v = '{10'h155, 10'h2aa}; seg_n = '{3, 2};
    do_record("pre_rst");
    replay = 1'b0;
    to_phase(0);
    replay = 1'b1;
    to_phase(TICK - 1);
    check("mid play playing", 32'(play_a), 32'(1));
    async_rst("rst_play");
    empty_replay("after_rst");

    // reset in the middle of recording
    rec = 1'b0;
    to_phase(0);
    {button, key} = 10'h3c5;
    rec = 1'b1;
    to_phase(0);
    to_phase(0);
    check("mid rec recording", 32'(rec_a), 32'(1));
    async_rst("rst_rec");
    @(negedge clk);
    check("post rst count", 32'(count_a), 32'(0));
    check("post rst light", 32'(light_a), 32'({1'b0, button, key}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
